// File: rtl/mod_red_512.sv
// mod_red_512: sequential modular reducer for the 512-bit multiplier product.
// Computes rmul_i mod rmod_i with restoring shift/compare/subtract, one
// product bit per clock (MSB first), and returns a 256-bit residue.
// A start pulse is accepted in any state and silently aborts any job in flight.
// A zero modulus skips the run phase and reports an error together with rend_o.
module mod_red_512 #(
    parameter int PW = 512,
    parameter int MW = 256
) (
    input  logic          clk_i,
    input  logic          arst_ni,
    input  logic          rstr_i,
    input  logic [PW-1:0] rmul_i,
    input  logic [MW-1:0] rmod_i,
    output logic          rbsy_o,
    output logic          rend_o,
    output logic          rerr_o,
    output logic [MW-1:0] rres_o
);

    localparam int CW = $clog2(PW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;

    // pr is shifted left each RUN cycle, so its MSB is always the next
    // dividend bit (equivalent to indexing pr[PW-1-cnt]).
    logic [PW-1:0] pr;
    logic [MW-1:0] md;
    // The running remainder is kept below md, so its MW+1-bit form always has
    // a zero top bit; only the low MW bits need storage.
    logic [MW-1:0] rem;
    logic [CW-1:0] cnt;

    logic [MW-1:0] rem_nxt;
    logic          last;
    logic          mod_zero;

    // One reduction step: shift in the next dividend bit and subtract the
    // modulus once if the widened value reaches it. Because rem < m, the
    // shifted value t < 2*m, so one conditional subtract restores rem < m.
    // The compare runs on MW+1 bits; the subtract can drop the top bit since
    // the true difference is below m and therefore fits in MW bits.
    function automatic logic [MW-1:0] red_step(
        input logic [MW-1:0] r,
        input logic          b,
        input logic [MW-1:0] m
    );
        logic [MW:0] t;
        t = {r, b};
        if (t >= {1'b0, m}) begin
            red_step = t[MW-1:0] - m;
        end else begin
            red_step = t[MW-1:0];
        end
    endfunction

    assign rem_nxt  = red_step(rem, pr[PW-1], md);
    assign last     = (cnt == CW'(PW - 1));
    assign mod_zero = (rmod_i == '0);

    // State register.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a start pulse overrides whatever the FSM is doing.
    always_comb begin
        state_d = state_q;
        if (rstr_i) begin
            state_d = mod_zero ? DONE : RUN;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                RUN:     state_d = last ? DONE : RUN;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode: busy for the whole job, including the done cycle.
    always_comb begin
        rbsy_o = (state_q == RUN) || (state_q == DONE);
    end

    // Registered done/error flags, high exactly while the FSM sits in DONE.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rend_o <= 1'b0;
            rerr_o <= 1'b0;
        end else begin
            rend_o <= (state_d == DONE);
            rerr_o <= rstr_i && mod_zero;
        end
    end

    // Datapath: load operands on start, one shift/subtract step per RUN cycle.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            pr     <= '0;
            md     <= '0;
            rem    <= '0;
            cnt    <= '0;
            rres_o <= '0;
        end else if (rstr_i) begin
            pr     <= rmul_i;
            md     <= rmod_i;
            rem    <= '0;
            cnt    <= '0;
            rres_o <= '0;
        end else if (state_q == RUN) begin
            pr  <= pr << 1;
            rem <= rem_nxt;
            cnt <= cnt + 1'b1;
            if (last) begin
                rres_o <= rem_nxt;
            end
        end
    end

endmodule
